// File: rtl/fluid_ctrl_pkg.sv
// Shared types, defaults and index helper for the inlet dose sequencer.
// Solution masks are passed at MAX_SOLN width so the helper serves any N_SOLN up to that.
package fluid_ctrl_pkg;

    localparam int CNT_W_DEF  = 16;
    localparam int N_SOLN_DEF = 3;
    localparam int MAX_SOLN   = 8;
    localparam int IDX_W      = 3;

    typedef enum logic [1:0] {
        IDLE,
        DOSE,
        SETTLE,
        WAIT_OUT
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } nz_t;

    // Lowest index >= from_idx whose dose length is non-zero.
    function automatic nz_t next_nonzero(input logic [MAX_SOLN-1:0] lens_nz,
                                         input logic [IDX_W:0]      from_idx);
        nz_t r;
        r = '0;
        for (int i = MAX_SOLN - 1; i >= 0; i--) begin
            if (lens_nz[i] && (i >= int'(from_idx))) begin
                r.valid = 1'b1;
                r.idx   = IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fluid_dose_sequencer_if.sv
// Command/status bundle between the fluidic host and the dose sequencer.
interface fluid_dose_sequencer_if
    import fluid_ctrl_pkg::*;
#(
    parameter int N_SOLN = N_SOLN_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    logic                    start;
    logic                    abort;
    logic [N_SOLN*CNT_W-1:0] dose_len;
    logic                    out_sense;
    logic [N_SOLN-1:0]       valve_en;
    logic                    pump_en;
    logic                    busy;
    logic                    done;
    logic                    err_timeout;

    modport master (
        output start, abort, dose_len, out_sense,
        input  valve_en, pump_en, busy, done, err_timeout
    );

    modport slave (
        input  start, abort, dose_len, out_sense,
        output valve_en, pump_en, busy, done, err_timeout
    );
endinterface

// File: rtl/fluid_dose_sequencer_timer.sv
// Load/decrement phase timer; terminal count flags the last cycle of a phase.
// Saturates at zero so it never wraps.
module fluid_down_timer
    import fluid_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_tc
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_tc = (r_count <= CNT_W'(1));
endmodule

// File: rtl/fluid_dose_sequencer.sv
// Inlet-side dose sequencer: timed valve doses, settle gaps, then wait for outlet fluid.
// Outputs are registered from the next state so they track the state entered on each edge.
module fluid_dose_sequencer
    import fluid_ctrl_pkg::*;
#(
    parameter int N_SOLN      = N_SOLN_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SETTLE_CYC  = 8,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fluid_dose_sequencer_if.slave  bus
);
    state_t                  r_state, w_state_nxt;
    logic [IDX_W-1:0]        r_idx, w_idx_nxt;
    logic [N_SOLN*CNT_W-1:0] r_lens;
    logic [MAX_SOLN-1:0]     w_nz_in, w_nz_lat;
    nz_t                     w_first, w_next;
    logic                    w_ld, w_dec, w_tc, w_latch, w_done_nxt, w_err_nxt;
    logic [CNT_W-1:0]        w_ld_val;
    logic [N_SOLN-1:0]       r_valve;
    logic                    r_pump, r_busy, r_done, r_err;

    always_comb begin
        w_nz_in  = '0;
        w_nz_lat = '0;
        for (int i = 0; i < N_SOLN; i++) begin
            w_nz_in[i]  = |bus.dose_len[i*CNT_W +: CNT_W];
            w_nz_lat[i] = |r_lens[i*CNT_W +: CNT_W];
        end
    end

    // First dose comes from the live input (it is latched on that same edge); later ones from the latch.
    assign w_first = next_nonzero(w_nz_in, '0);
    assign w_next  = next_nonzero(w_nz_lat, (IDX_W+1)'(r_idx) + (IDX_W+1)'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_ld        = 1'b0;
        w_ld_val    = '0;
        w_dec       = 1'b0;
        w_latch     = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;
        if (r_state == IDLE) begin
            if (bus.start) begin
                w_latch   = 1'b1;
                w_err_nxt = 1'b0;
                w_ld      = 1'b1;
                if (w_first.valid) begin
                    w_state_nxt = DOSE;
                    w_idx_nxt   = w_first.idx;
                    w_ld_val    = bus.dose_len[int'(w_first.idx)*CNT_W +: CNT_W];
                end else begin
                    w_state_nxt = WAIT_OUT;
                    w_idx_nxt   = '0;
                    w_ld_val    = CNT_W'(TIMEOUT_CYC);
                end
            end
        end else if (bus.abort) begin
            w_state_nxt = IDLE;
            w_ld        = 1'b1;
        end else begin
            w_dec = 1'b1;
            case (r_state)
                DOSE: begin
                    if (w_tc) begin
                        w_state_nxt = SETTLE;
                        w_ld        = 1'b1;
                        w_ld_val    = CNT_W'(SETTLE_CYC);
                    end
                end
                SETTLE: begin
                    if (w_tc) begin
                        w_ld = 1'b1;
                        if (w_next.valid) begin
                            w_state_nxt = DOSE;
                            w_idx_nxt   = w_next.idx;
                            w_ld_val    = r_lens[int'(w_next.idx)*CNT_W +: CNT_W];
                        end else begin
                            w_state_nxt = WAIT_OUT;
                            w_ld_val    = CNT_W'(TIMEOUT_CYC);
                        end
                    end
                end
                WAIT_OUT: begin
                    if (bus.out_sense) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                        w_ld        = 1'b1;
                    end else if (w_tc) begin
                        w_state_nxt = IDLE;
                        w_err_nxt   = 1'b1;
                        w_ld        = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    fluid_down_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_ld),
        .i_dec      (w_dec),
        .i_load_val (w_ld_val),
        .o_tc       (w_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_valve <= '0;
            r_pump  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_valve <= (w_state_nxt == DOSE) ? (N_SOLN'(1) << w_idx_nxt) : '0;
            r_pump  <= (w_state_nxt != IDLE);
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_latch) begin
            r_lens <= bus.dose_len;
        end
    end

    assign bus.valve_en    = r_valve;
    assign bus.pump_en     = r_pump;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.err_timeout = r_err;
endmodule

// File: tb/tb_fluid_dose_sequencer.sv
// Randomized bench for fluid_dose_sequencer: a per-cycle expected trace is built from the
// dose/settle/wait rules and compared against the outputs on every falling edge.
module tb_fluid_dose_sequencer;
    localparam int N   = 3;
    localparam int CW  = 16;
    localparam int SET = 8;
    localparam int TO  = 20;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic model_err;

    fluid_dose_sequencer_if #(.N_SOLN(N), .CNT_W(CW)) bus ();

    fluid_dose_sequencer #(
        .N_SOLN(N), .CNT_W(CW), .SETTLE_CYC(SET), .TIMEOUT_CYC(TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        assert ($onehot0(bus.valve_en))
        else $error("FAIL onehot: valve_en=%b required at most one bit set", bus.valve_en);
    end

    // v=valve, a=pump/busy, d=done, e=err_timeout, s=out_sense to drive, f=out_sense is don't-care
    typedef struct {
        logic [2:0] v;
        logic       a;
        logic       d;
        logic       e;
        logic       s;
        logic       f;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic [2:0] v, input logic a, input logic d,
                        input logic e, input logic s, input logic f);
        exp_t x;
        x.v = v; x.a = a; x.d = d; x.e = e; x.s = s; x.f = f;
        q.push_back(x);
    endtask

    // Expected trace for one accepted start: entry c is the output after the c-th edge following it.
    task automatic build(input int l0, input int l1, input int l2, input int k);
        int  lens[3];
        int  w;
        bit  ok;
        lens = '{l0, l1, l2};
        q.delete();
        for (int i = 0; i < N; i++) begin
            if (lens[i] > 0) begin
                repeat (lens[i]) push(3'(1 << i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
                repeat (SET) push(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            end
        end
        ok = (k >= 1) && (k <= TO);
        w  = ok ? k : TO;
        for (int j = 1; j <= w; j++) push(3'b000, 1'b1, 1'b0, 1'b0, (j == k), 1'b0);
        push(3'b000, 1'b0, ok, !ok, 1'b0, 1'b1);
    endtask

    // Abort or reset during cycle c: the next entry is idle with every output low.
    task automatic cut(input int c);
        while (q.size() > c + 1) void'(q.pop_back());
        push(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic cmp(input int c, input exp_t x);
        chk($sformatf("valve c%0d", c), 32'(bus.valve_en), 32'(x.v));
        chk($sformatf("pump c%0d", c), 32'(bus.pump_en), 32'(x.a));
        chk($sformatf("busy c%0d", c), 32'(bus.busy), 32'(x.a));
        chk($sformatf("done c%0d", c), 32'(bus.done), 32'(x.d));
        chk($sformatf("err c%0d", c), 32'(bus.err_timeout), 32'(x.e));
    endtask

    // Called at a falling edge; returns at a falling edge with the design back in IDLE.
    // ab/rs: cycle to abort/reset in, -1 none, -2 pick at random.
    task automatic run_seq(input int l0, input int l1, input int l2, input int k,
                           input int ab, input int rs, input bit noise);
        int last;
        build(l0, l1, l2, k);
        if (ab == -2) ab = $urandom_range(0, q.size() - 2);
        if (rs == -2) rs = $urandom_range(0, q.size() - 2);
        if (ab >= 0) cut(ab);
        if (rs >= 0) cut(rs);
        last = q.size() - 1;
        bus.dose_len  = {CW'(l2), CW'(l1), CW'(l0)};
        bus.start     = 1'b1;
        bus.abort     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.out_sense = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        rst_n         = 1'b1;
        @(posedge clk);
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            cmp(c, q[c]);
            bus.start     = (noise && c < last) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.abort     = (c == ab);
            rst_n         = !(c == rs);
            bus.out_sense = q[c].f ? (noise ? 1'($urandom_range(0, 1)) : 1'b0) : q[c].s;
            if (noise && c < last) bus.dose_len = {CW'($urandom), CW'($urandom), CW'($urandom)};
            if (c < last) @(posedge clk);
        end
        model_err = q[last].e;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        rst_n     = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            bus.abort     = 1'($urandom_range(0, 1));
            bus.out_sense = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            chk("idle valve", 32'(bus.valve_en), 32'(0));
            chk("idle busy", 32'(bus.busy), 32'(0));
            chk("idle pump", 32'(bus.pump_en), 32'(0));
            chk("idle done", 32'(bus.done), 32'(0));
            chk("idle err", 32'(bus.err_timeout), 32'(model_err));
        end
        bus.abort = 1'b0;
    endtask

    function automatic int rlen();
        return ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 6));
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        model_err = 1'b0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.out_sense = 1'b0;
        bus.dose_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset valve", 32'(bus.valve_en), 32'(0));
        chk("reset pump", 32'(bus.pump_en), 32'(0));
        chk("reset busy", 32'(bus.busy), 32'(0));
        chk("reset done", 32'(bus.done), 32'(0));
        chk("reset err", 32'(bus.err_timeout), 32'(0));

        run_seq(4, 2, 5, 3, -1, -1, 1'b0);
        run_seq(0, 6, 0, 5, -1, -1, 1'b0);
        run_seq(0, 0, 0, 0, -1, -1, 1'b0);
        idle(2);
        run_seq(4, 2, 5, 3, 1, -1, 1'b0);
        run_seq(4, 2, 5, 2, -1, -1, 1'b1);
        run_seq(4, 2, 5, 3, -1, 6, 1'b0);
        idle(1);

        for (int t = 0; t < 40; t++) begin
            int sel;
            sel = $urandom_range(0, 7);
            run_seq(rlen(), rlen(), rlen(), $urandom_range(0, TO + 3),
                    (sel == 0) ? -2 : -1, (sel == 1) ? -2 : -1, 1'b1);
            idle($urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fluid_dose_sequencer.md
Name: fluid_dose_sequencer

Overview:
- Clocked controller on the inlet side of the smart_toilet fluidic netlist.
- Drives the soln1..soln3 inlet valves and the pump that feed the serpentine/diffmix network.
- Watches the outlet presence sensor on `out`.
- Sequences timed doses of each solution, waits for mixed fluid to reach the outlet, and reports done or timeout.

Parameters:
- N_SOLN, 3, number of inlet solutions/valves.
- CNT_W, 16, width of dose-length and timer counters.
- SETTLE_CYC, 8, closed-valve settle cycles after each non-zero dose (≥1).
- TIMEOUT_CYC, 1000, maximum cycles to wait for out_sense (≥1, < 2^CNT_W).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin a sequence; sampled only in IDLE.
- abort  in  1  cancel the sequence; effective in any non-IDLE state.
- dose_len  in  N_SOLN*CNT_W  per-solution open time in cycles; slice i = [i*CNT_W +: CNT_W]; 0 = skip.
- out_sense  in  1  outlet fluid detected (already synchronised).
- valve_en  out  N_SOLN  inlet valve opens; one-hot or zero.
- pump_en  out  1  pressure source enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on successful completion.
- err_timeout  out  1  sticky; set on timeout, cleared by the next accepted start or reset.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, idx=0, counters=0; every output 0, including err_timeout.
- All outputs are registered and decoded from next-state, so valve_en reflects the state entered on the same edge.
- Config latch: dose_len is captured into internal registers on the cycle start is accepted. Later changes to dose_len are ignored until the next start.
- IDLE:
  - start=1 → err_timeout cleared, idx set to the first i with non-zero length.
  - Go to DOSE(idx); if all lengths are 0, go directly to WAIT_OUT.
- DOSE(i):
  - valve_en = 1<<i, pump_en=1.
  - Valve is high for exactly len[i] cycles, then go to SETTLE.
- SETTLE:
  - valve_en=0, pump_en=1, for exactly SETTLE_CYC cycles.
  - Then go to DOSE of the next non-zero index > i. If none remains, go to WAIT_OUT.
- WAIT_OUT:
  - valve_en=0, pump_en=1; the timer counts from 0.
  - out_sense=1 → go to IDLE with done=1 for exactly one cycle.
  - Timer reaches TIMEOUT_CYC without out_sense → go to IDLE, err_timeout=1, done stays 0.
  - out_sense on the final timeout cycle counts as success.
- out_sense is ignored outside WAIT_OUT.
- abort: in any non-IDLE state, the next edge gives IDLE with valve_en=0 and pump_en=0. No done pulse; err_timeout is unchanged.
- Precedence: rst_n > abort > out_sense/timeout > normal transitions.
- start while busy is ignored. start and abort together in IDLE: start is accepted.
- Counter widths:
  - Dose/settle/timeout counters are CNT_W bits and never wrap.
  - len = 2^CNT_W-1 is a legal maximum.
  - The comparison is done against the terminal count, not by wrap-around.
- Invariant: at most one valve_en bit is high in any cycle. A bench assertion checks this.
- Back-to-back: done and IDLE occur on the same cycle. start on the next cycle begins a new sequence with no gap penalty.

Decomposition:
- Package fluid_ctrl_pkg holds:
  - state enum: IDLE, DOSE, SETTLE, WAIT_OUT.
  - default CNT_W.
  - helper function next_nonzero(lens, from_idx) → index plus a valid flag.
- One sub-module, fluid_down_timer: CNT_W-bit load/decrement counter with a terminal-count flag.
  - Shared by the dose, settle and timeout phases, because only one phase is active at a time.

Test Plan:
- Reset, then dose_len={3:5, 2:2, 1:4} (soln3:soln2:soln1), start pulse, out_sense asserted 3 cycles into WAIT_OUT → expected sequence:
  - valve_en=001 for 4 cycles, 0 for 8, 010 for 2, 0 for 8, 100 for 5, 0 for 8.
  - 3 cycles of WAIT_OUT, then done=1 for one cycle; pump_en is high for the whole run.
- dose_len={3:0, 2:6, 1:0} → only valve_en=010, for 6 cycles, then settle 8 and WAIT_OUT; soln1/soln3 never open.
- All lengths 0, TIMEOUT_CYC=20, out_sense held 0 → WAIT_OUT for 20 cycles, then IDLE with err_timeout=1 and no done. A new start clears err_timeout.
- abort on the 2nd cycle of DOSE(1) → next cycle valve_en=0, pump_en=0, busy=0, no done. start on the following cycle restarts from soln1.
- start pulsed repeatedly while busy, and dose_len changed mid-run → timing matches the values latched at the first start; no extra sequences.
- rst_n=0 during SETTLE → all outputs 0 on the next edge; one-hot valve assertion holds throughout the randomized-length regression.
